pwm_update_sequencer: RTL and testbench
=======================================

# pwm_update_sequencer

Master-side controller for the three-phase center-aligned PWM modulator. It drives the modulator's Avalon-MM register slave. After reset it programs the modulator's sync configuration, then turns each accepted duty command into a fixed burst of register writes ending in an update request, and holds off the next command until the modulator signals the sync point. A fault input takes priority over commands and forces all phases to the all-off state.

## Interface
- `DEADTIME`, 16'd50: half-width of the dead band in counter ticks, applied to each phase.
- `SYNC_AT_MAX`, 0: 0 = shadow load and IRQ at counter zero; 1 = at counter max.

- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  duty command present
- `cmd_ready`  out  1  command accepted when valid & ready
- `cmd_center`  in  48  three 16-bit phase compare centers; phase 0 is [15:0]
- `cmd_period`  in  16  counter max value
- `fault`  in  1  level; forces safe state
- `pwm_irq`  in  1  modulator sync pulse (one cycle)
- `pwm_addr`  out  4  register address, registered
- `pwm_write`  out  1  write strobe, registered
- `pwm_writedata`  out  32  write data, registered
- `fault_active`  out  1  safe state in force
- `busy`  out  1  not IDLE

## Operation
- The slave has no waitrequest: one write per cycle and no stalls.
- Deadband arithmetic, per phase, on center c (16-bit unsigned):
  - low = (c > DEADTIME) ? c − DEADTIME : 0.
  - high = (c > 16'hFFFF − DEADTIME) ? 16'hFFFF : c + DEADTIME.
  - Computed in 17 bits and saturated. Write data is zero-extended to 32 bits.
- States:
  - **INIT**: 4 writes:
    - addr A = ~SYNC_AT_MAX
    - B = SYNC_AT_MAX
    - C = ~SYNC_AT_MAX
    - D = SYNC_AT_MAX
    - Then go to IDLE, or to SAFE_LOAD if `fault` is high.
  - **IDLE**: `cmd_ready` = 1 unless `fault`.
    - On accept, register the computed low/high values and the period, then go to LOAD.
    - `fault` high: go to SAFE_LOAD. Fault wins over a simultaneous `cmd_valid`, and no accept occurs.
  - **LOAD**: 8 writes in order: addr 0 low0, 1 high0, 2 low1, 3 high1, 4 low2, 5 high2, 8 period, F data 1. Then go to WAIT_SYNC.
  - **WAIT_SYNC**: wait for `pwm_irq`, then go to IDLE. A `pwm_irq` in any other state is ignored.
  - **SAFE_LOAD**: 7 writes: addr 0/2/4 data 0, addr 1/3/5 data FFFF, addr F data 1. Then go to SAFE_HOLD. The period is left unchanged.
  - **SAFE_HOLD**: `fault_active` = 1.
    - Go to IDLE when `fault` is low and `pwm_irq` has been seen since entering SAFE_LOAD.
    - Otherwise stay.
- `fault` rising during LOAD or WAIT_SYNC:
  - Abort at the next edge and go to SAFE_LOAD, starting at addr 0.
  - No further command writes are issued.
- `fault` high during INIT: INIT completes first, then the block goes to SAFE_LOAD.
- `fault` re-asserting during SAFE_LOAD or SAFE_HOLD: no restart.
- `fault_active` is 1 from SAFE_LOAD entry until leaving SAFE_HOLD.

## Timing
- Reset values: `pwm_write` 0, `pwm_addr` 0, `pwm_writedata` 0, `cmd_ready` 0, `fault_active` 0, `busy` 1 (INIT).
- First INIT write is in the first cycle after `reset_n` deasserts. IDLE is reached 4 cycles later.
- A command accepted at edge T produces writes at cycles T+1 … T+8; the update write (addr F) is at T+8.
- `cmd_ready` drops at T+1. It rises no earlier than one cycle after `pwm_irq` is sampled.
- Fault sampled at edge T: the first safe write (addr 0) is at T+1 and the addr F write is at T+7.
- `cmd_ready` and `busy` are decoded from state (registered state, combinational decode). `cmd_ready` additionally gated by `fault`.
- Reset mid-burst: all outputs return to reset values immediately and the block restarts in INIT.

## Structure
- Shared package `pwm_pkg` holds:
  - register address constants: CMPL0..CMPH2, MAXCTR, UPD0, UPDMAX, TRIG0, TRIGMAX, UPDATE
  - the state enum
  - the safe low/high constants
- One sub-module, `pwm_deadband`: combinational saturating center-to-(low, high) for one phase, instantiated three times.

## Test plan
- Reset release, SYNC_AT_MAX=0 -> writes A=1, B=0, C=1, D=0 in cycles 1–4, then `cmd_ready` = 1.
- Command centers {0x8000, 0x0010, 0xFFF0}, period 0xFFFF, DEADTIME 50 -> writes in order:
  - 0:7FCE, 1:8032
  - 2:0000, 3:0042
  - 4:FFBE, 5:FFFF
  - 8:FFFF, F:1
  - `cmd_ready` stays 0 until `pwm_irq`.
- Second `cmd_valid` held during WAIT_SYNC -> no writes until `pwm_irq`. Accepted the cycle after the IRQ, and its first write comes one cycle after acceptance.
- `fault` asserted at the 3rd LOAD write -> next cycle addr 0 data 0, then 1:FFFF … F:1 (7 writes). `fault_active` = 1 and no further command writes.
- `fault` deasserted before any `pwm_irq` -> stays in SAFE_HOLD; a subsequent `pwm_irq` -> IDLE, with `fault_active` = 0 and `cmd_ready` = 1.
- `cmd_valid` and `fault` rise in the same IDLE cycle -> no accept; the safe burst is issued.

Source files
------------

// File: rtl/pwm_update_sequencer_pkg.sv
// Shared definitions for the PWM update sequencer: register map, FSM states, safe-state values.
// Latency: none (declarations and pure combinational helpers only).
// Backpressure: not applicable.
package pwm_pkg;

   // Modulator register map
   localparam logic [3:0] CMPL0   = 4'h0;
   localparam logic [3:0] CMPH0   = 4'h1;
   localparam logic [3:0] CMPL1   = 4'h2;
   localparam logic [3:0] CMPH1   = 4'h3;
   localparam logic [3:0] CMPL2   = 4'h4;
   localparam logic [3:0] CMPH2   = 4'h5;
   localparam logic [3:0] MAXCTR  = 4'h8;
   localparam logic [3:0] UPD0    = 4'hA;
   localparam logic [3:0] UPDMAX  = 4'hB;
   localparam logic [3:0] TRIG0   = 4'hC;
   localparam logic [3:0] TRIGMAX = 4'hD;
   localparam logic [3:0] UPDATE  = 4'hF;

   // All-off compare values: low edge at zero, high edge at full scale
   localparam logic [15:0] SAFE_LOW  = 16'h0000;
   localparam logic [15:0] SAFE_HIGH = 16'hFFFF;

   localparam int N_PHASES = 3;

   // Index of the last write slot in each burst
   localparam logic [2:0] INIT_LAST = 3'd3;
   localparam logic [2:0] LOAD_LAST = 3'd7;
   localparam logic [2:0] SAFE_LAST = 3'd6;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_SYNC,
      ST_SAFE_LOAD,
      ST_SAFE_HOLD
   } state_t;

   // Dead-band-adjusted compare pair for one phase
   typedef struct packed {
      logic [15:0] high;
      logic [15:0] low;
   } edges_t;

   // Sync configuration register written in each INIT slot
   function automatic logic [3:0] init_addr(input logic [1:0] slot);
      case (slot)
         2'd0:    return UPD0;
         2'd1:    return UPDMAX;
         2'd2:    return TRIG0;
         default: return TRIGMAX;
      endcase
   endfunction

   // Register written in each command burst slot
   function automatic logic [3:0] load_addr(input logic [2:0] slot);
      case (slot)
         3'd0:    return CMPL0;
         3'd1:    return CMPH0;
         3'd2:    return CMPL1;
         3'd3:    return CMPH1;
         3'd4:    return CMPL2;
         3'd5:    return CMPH2;
         3'd6:    return MAXCTR;
         default: return UPDATE;
      endcase
   endfunction

   // Register written in each safe burst slot; the period register is skipped
   function automatic logic [3:0] safe_addr(input logic [2:0] slot);
      case (slot)
         3'd0:    return CMPL0;
         3'd1:    return CMPH0;
         3'd2:    return CMPL1;
         3'd3:    return CMPH1;
         3'd4:    return CMPL2;
         3'd5:    return CMPH2;
         default: return UPDATE;
      endcase
   endfunction

endpackage

// File: rtl/pwm_update_sequencer_if.sv
// Command channel and modulator register bus between sequencer and its environment.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; register bus has no waitrequest.
interface pwm_update_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [47:0] cmd_center;
   logic [15:0] cmd_period;
   logic        pwm_irq;
   logic [3:0]  pwm_addr;
   logic        pwm_write;
   logic [31:0] pwm_writedata;

   // Sequencer side: accepts commands, drives the register bus
   modport master (
      input  cmd_valid, cmd_center, cmd_period, pwm_irq,
      output cmd_ready, pwm_addr, pwm_write, pwm_writedata
   );

   // Environment side: command source plus modulator register slave
   modport slave (
      output cmd_valid, cmd_center, cmd_period, pwm_irq,
      input  cmd_ready, pwm_addr, pwm_write, pwm_writedata
   );
endinterface

// File: rtl/pwm_update_sequencer_deadband.sv
// Saturating center-to-(low, high) compare pair for one phase.
// Latency: combinational.
// Backpressure: none.
module pwm_deadband
   import pwm_pkg::*;
#(
   parameter logic [15:0] DEADTIME = 16'd50
) (
   input  logic [15:0] center,
   output edges_t      edges
);

   logic [16:0] sum;
   logic [16:0] diff;

   // 17-bit add/subtract; the extra bit flags overflow/borrow and selects the clamp
   always_comb begin
      sum        = {1'b0, center} + {1'b0, DEADTIME};
      diff       = {1'b0, center} - {1'b0, DEADTIME};
      edges.high = sum[16]  ? 16'hFFFF : sum[15:0];
      edges.low  = diff[16] ? 16'h0000 : diff[15:0];
   end

endmodule

// File: rtl/pwm_update_sequencer.sv
// Sequences modulator register writes: sync setup after reset, per-command compare burst, fault safe burst.
// Latency: first write one cycle after reset release / command accept / fault sample; one write per cycle.
// Backpressure: cmd_ready only in IDLE without fault; next command held off until the modulator sync IRQ.
module pwm_update_sequencer
   import pwm_pkg::*;
#(
   parameter logic [15:0] DEADTIME    = 16'd50,
   parameter bit          SYNC_AT_MAX = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   pwm_update_sequencer_if.master        bus,
   input  logic                          fault,
   output logic                          fault_active,
   output logic                          busy
);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        irq_seen_q, irq_seen_d;
   logic        wr_q, wr_d;
   logic [3:0]  addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        cmd_accept;
   logic        ready_int;

   edges_t      db     [N_PHASES];
   edges_t      cmd_q  [N_PHASES];
   logic [15:0] period_q;

   logic [15:0] init_word;
   logic [15:0] load_word;
   logic [15:0] safe_word;

   for (genvar p = 0; p < N_PHASES; p++) begin : g_db
      pwm_deadband #(.DEADTIME(DEADTIME)) u_db (
         .center (bus.cmd_center[16*p +: 16]),
         .edges  (db[p])
      );
   end

   assign ready_int     = (state_q == ST_IDLE) && !fault;
   assign bus.cmd_ready = ready_int;
   assign busy          = (state_q != ST_IDLE);
   assign fault_active  = (state_q == ST_SAFE_LOAD) || (state_q == ST_SAFE_HOLD);

   assign bus.pwm_write     = wr_q;
   assign bus.pwm_addr      = addr_q;
   assign bus.pwm_writedata = wdat_q;

   // Data word for the current slot of each burst type
   always_comb begin
      init_word = {15'b0, (idx_q[0] ? SYNC_AT_MAX : ~SYNC_AT_MAX)};
      safe_word = (idx_q == SAFE_LAST) ? 16'h0001 : (idx_q[0] ? SAFE_HIGH : SAFE_LOW);
      load_word = 16'h0001;
      case (idx_q)
         3'd0:    load_word = cmd_q[0].low;
         3'd1:    load_word = cmd_q[0].high;
         3'd2:    load_word = cmd_q[1].low;
         3'd3:    load_word = cmd_q[1].high;
         3'd4:    load_word = cmd_q[2].low;
         3'd5:    load_word = cmd_q[2].high;
         3'd6:    load_word = period_q;
         default: load_word = 16'h0001;
      endcase
   end

   // Next state, slot counter and next register-bus write
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      irq_seen_d = irq_seen_q;
      wr_d       = 1'b0;
      addr_d     = addr_q;
      wdat_d     = wdat_q;
      cmd_accept = 1'b0;

      case (state_q)
         ST_INIT: begin
            wr_d   = 1'b1;
            addr_d = init_addr(idx_q[1:0]);
            wdat_d = {16'h0000, init_word};
            if (idx_q == INIT_LAST) begin
               // A fault seen during setup is honoured only once setup is complete
               idx_d      = '0;
               irq_seen_d = 1'b0;
               state_d    = fault ? ST_SAFE_LOAD : ST_IDLE;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end

         ST_IDLE: begin
            if (fault) begin
               state_d    = ST_SAFE_LOAD;
               idx_d      = '0;
               irq_seen_d = 1'b0;
            end else if (bus.cmd_valid) begin
               cmd_accept = 1'b1;
               state_d    = ST_LOAD;
               idx_d      = '0;
            end
         end

         ST_LOAD: begin
            if (fault) begin
               // Abort: this edge issues no command write
               state_d    = ST_SAFE_LOAD;
               idx_d      = '0;
               irq_seen_d = 1'b0;
            end else begin
               wr_d   = 1'b1;
               addr_d = load_addr(idx_q);
               wdat_d = {16'h0000, load_word};
               if (idx_q == LOAD_LAST) begin
                  idx_d   = '0;
                  state_d = ST_WAIT_SYNC;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         ST_WAIT_SYNC: begin
            if (fault) begin
               state_d    = ST_SAFE_LOAD;
               idx_d      = '0;
               irq_seen_d = 1'b0;
            end else if (bus.pwm_irq) begin
               state_d = ST_IDLE;
            end
         end

         ST_SAFE_LOAD: begin
            wr_d   = 1'b1;
            addr_d = safe_addr(idx_q);
            wdat_d = {16'h0000, safe_word};
            if (bus.pwm_irq) irq_seen_d = 1'b1;
            if (idx_q == SAFE_LAST) begin
               idx_d   = '0;
               state_d = ST_SAFE_HOLD;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end

         ST_SAFE_HOLD: begin
            // Leave only once the safe values have reached the modulator via a sync point
            if (bus.pwm_irq) irq_seen_d = 1'b1;
            if (!fault && (irq_seen_q || bus.pwm_irq)) state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_INIT;
            idx_d   = '0;
         end
      endcase
   end

   // FSM state and registered register-bus outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_INIT;
         idx_q      <= '0;
         irq_seen_q <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdat_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         irq_seen_q <= irq_seen_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdat_q     <= wdat_d;
      end
   end

   // Capture dead-band pairs and period when a command is accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < N_PHASES; p++) cmd_q[p] <= '0;
         period_q <= '0;
      end else if (cmd_accept) begin
         for (int p = 0; p < N_PHASES; p++) cmd_q[p] <= db[p];
         period_q <= bus.cmd_period;
      end
   end

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Scoreboard bench for pwm_update_sequencer: expected writes queued at stimulus time, popped by a bus monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_update_sequencer;

   localparam logic [15:0] DT = 16'd50;

   typedef struct packed {
      logic [3:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic fault   = 1'b0;
   logic fault_active;
   logic busy;

   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q [$];
   wr_t  mon_e;
   logic [47:0] rc;
   logic [15:0] rp;

   pwm_update_sequencer_if bus ();

   pwm_update_sequencer #(.DEADTIME(DT), .SYNC_AT_MAX(1'b0)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .fault        (fault),
      .fault_active (fault_active),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   // Bus monitor: every write must match the head of the expected queue
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.pwm_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: actual addr %h data %h, required no write", bus.pwm_addr, bus.pwm_writedata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(bus.pwm_addr), 32'(mon_e.addr));
            check("wr_data", bus.pwm_writedata, mon_e.data);
         end
      end
   end

   // Reference dead-band arithmetic in plain integers
   function automatic logic [15:0] ref_low(input logic [15:0] c);
      int v;
      v = int'(c) - int'(DT);
      return (v < 0) ? 16'h0000 : v[15:0];
   endfunction

   function automatic logic [15:0] ref_high(input logic [15:0] c);
      int v;
      v = int'(c) + int'(DT);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   function automatic wr_t mk(input logic [3:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = {16'h0000, d};
      return e;
   endfunction

   // Expected command burst, truncated to the first n writes
   task automatic push_cmd(input logic [47:0] c, input logic [15:0] p, input int n);
      wr_t s [$];
      for (int i = 0; i < 3; i++) begin
         s.push_back(mk(4'(2*i),   ref_low(c[16*i +: 16])));
         s.push_back(mk(4'(2*i+1), ref_high(c[16*i +: 16])));
      end
      s.push_back(mk(4'h8, p));
      s.push_back(mk(4'hF, 16'h0001));
      for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
   endtask

   task automatic push_safe();
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(4'(i), (i % 2 == 1) ? 16'hFFFF : 16'h0000));
      exp_q.push_back(mk(4'hF, 16'h0001));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_irq();
      bus.pwm_irq = 1'b1;
      step();
      bus.pwm_irq = 1'b0;
   endtask

   function automatic logic [15:0] rand_c16();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return DT;
         3:       return 16'hFFFF - DT;
         4:       return DT + 16'd1;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic send_cmd(input logic [47:0] c, input logic [15:0] p, input int nexp);
      bit acc;
      acc = 1'b0;
      bus.cmd_center = c;
      bus.cmd_period = p;
      bus.cmd_valid  = 1'b1;
      for (int i = 0; i < 64 && !acc; i++) begin
         if (bus.cmd_ready === 1'b1) acc = 1'b1;
         step();
      end
      bus.cmd_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL cmd_accept: actual no cmd_ready within 64 cycles, required accept");
      end else begin
         push_cmd(c, p, nexp);
      end
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      fault         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.pwm_irq   = 1'b0;
      step();
      step();
      check("rst_pwm_write", 32'(bus.pwm_write), 32'd0);
      check("rst_pwm_addr", 32'(bus.pwm_addr), 32'd0);
      check("rst_pwm_wdata", bus.pwm_writedata, 32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_fault_active", 32'(fault_active), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      exp_q.push_back(mk(4'hA, 16'h0001));
      exp_q.push_back(mk(4'hB, 16'h0000));
      exp_q.push_back(mk(4'hC, 16'h0001));
      exp_q.push_back(mk(4'hD, 16'h0000));
      reset_n = 1'b1;
      step();
      check("init_first_wr", 32'({bus.pwm_write, bus.pwm_addr}), 32'h1A);
      repeat (3) step();
      check("init_ready", 32'(bus.cmd_ready), 32'd1);
      check("init_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_center = '0;
      bus.cmd_period = '0;
      bus.pwm_irq    = 1'b0;

      do_reset();
      step();
      check("init_drained", 32'(exp_q.size()), 32'd0);

      // Directed command with literal expected values
      send_cmd({16'hFFF0, 16'h0010, 16'h8000}, 16'hFFFF, 0);
      exp_q.push_back(mk(4'h0, 16'h7FCE));
      exp_q.push_back(mk(4'h1, 16'h8032));
      exp_q.push_back(mk(4'h2, 16'h0000));
      exp_q.push_back(mk(4'h3, 16'h0042));
      exp_q.push_back(mk(4'h4, 16'hFFBE));
      exp_q.push_back(mk(4'h5, 16'hFFFF));
      exp_q.push_back(mk(4'h8, 16'hFFFF));
      exp_q.push_back(mk(4'hF, 16'h0001));
      check("ready_drop", 32'(bus.cmd_ready), 32'd0);
      check("no_wr_at_accept", 32'(bus.pwm_write), 32'd0);
      step();
      check("first_cmd_wr", 32'({bus.pwm_write, bus.pwm_addr}), 32'h10);
      repeat (7) step();
      check("upd_at_t8", 32'({bus.pwm_write, bus.pwm_addr}), 32'h1F);

      // Second command held during WAIT_SYNC
      rc = {rand_c16(), rand_c16(), rand_c16()};
      rp = 16'($urandom);
      bus.cmd_center = rc;
      bus.cmd_period = rp;
      bus.cmd_valid  = 1'b1;
      repeat (4) begin
         step();
         check("hold_wait_sync", 32'(bus.cmd_ready), 32'd0);
      end
      pulse_irq();
      check("ready_after_irq", 32'(bus.cmd_ready), 32'd1);
      step();
      bus.cmd_valid = 1'b0;
      push_cmd(rc, rp, 8);
      check("busy_after_accept", 32'(busy), 32'd1);
      step();
      check("second_first_wr", 32'({bus.pwm_write, bus.pwm_addr}), 32'h10);
      repeat (7) step();
      pulse_irq();
      check("idle_after_irq", 32'(busy), 32'd0);

      // Fault raised while the third command write is on the bus
      rc = {rand_c16(), rand_c16(), rand_c16()};
      send_cmd(rc, 16'($urandom), 3);
      repeat (3) step();
      fault = 1'b1;
      push_safe();
      step();
      check("abort_fault_active", 32'(fault_active), 32'd1);
      check("abort_no_wr", 32'(bus.pwm_write), 32'd0);
      step();
      check("safe_first_wr", 32'({bus.pwm_write, bus.pwm_addr}), 32'h10);
      repeat (6) step();
      check("safe_upd_t7", 32'({bus.pwm_write, bus.pwm_addr}), 32'h1F);
      fault = 1'b0;
      repeat (4) step();
      check("hold_no_irq_fa", 32'(fault_active), 32'd1);
      check("hold_no_irq_rdy", 32'(bus.cmd_ready), 32'd0);
      pulse_irq();
      check("exit_fault_active", 32'(fault_active), 32'd0);
      check("exit_ready", 32'(bus.cmd_ready), 32'd1);

      // cmd_valid and fault rising together in IDLE
      bus.cmd_center = {rand_c16(), rand_c16(), rand_c16()};
      bus.cmd_valid  = 1'b1;
      fault          = 1'b1;
      #1;
      check("fault_blocks_ready", 32'(bus.cmd_ready), 32'd0);
      push_safe();
      step();
      bus.cmd_valid = 1'b0;
      check("simul_fault_active", 32'(fault_active), 32'd1);
      repeat (7) step();
      pulse_irq();
      repeat (2) step();
      check("fault_still_held", 32'(fault_active), 32'd1);
      fault = 1'b0;
      step();
      check("release_ready", 32'(bus.cmd_ready), 32'd1);
      check("release_fa", 32'(fault_active), 32'd0);

      // Randomised commands, with ignored IRQs during LOAD and faults during WAIT_SYNC
      for (int n = 0; n < 24; n++) begin
         rc = {rand_c16(), rand_c16(), rand_c16()};
         rp = 16'($urandom);
         send_cmd(rc, rp, 8);
         for (int i = 1; i <= 8; i++) begin
            if (n % 3 == 1 && i == 3) bus.pwm_irq = 1'b1;
            step();
            bus.pwm_irq = 1'b0;
         end
         repeat ($urandom_range(0, 3)) step();
         check("rand_wait_sync", 32'(bus.cmd_ready), 32'd0);
         if (n % 5 == 4) begin
            fault = 1'b1;
            push_safe();
            repeat (8) step();
            fault = 1'b0;
            check("rand_safe_hold", 32'(fault_active), 32'd1);
         end
         pulse_irq();
         check("rand_back_ready", 32'(bus.cmd_ready), 32'd1);
      end

      // Reset in the middle of a burst
      rc = {rand_c16(), rand_c16(), rand_c16()};
      send_cmd(rc, 16'($urandom), 4);
      repeat (4) step();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_write", 32'(bus.pwm_write), 32'd0);
      check("midrst_addr", 32'(bus.pwm_addr), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_ready", 32'(bus.cmd_ready), 32'd0);
      do_reset();

      // Normal command after recovery
      send_cmd({rand_c16(), rand_c16(), rand_c16()}, 16'($urandom), 8);
      repeat (8) step();
      pulse_irq();
      repeat (3) step();
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
